// File: rtl/pb3_pkg.sv
// ============================================================================
// Module  : pb3_pkg
// Brief   : Shared state encoding and default constants for the ALU read side.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pb3_pkg;

    localparam int C_DEF_WIDTH   = 16;
    localparam int C_DEF_TIMEOUT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pb3_alu_read_if.sv
// ============================================================================
// Module  : pb3_alu_read_if
// Brief   : ALU result / IBUS read handshake bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pb3_alu_read_if #(
    parameter int WIDTH = pb3_pkg::C_DEF_WIDTH
);
    logic             nralu;
    logic [WIDTH-1:0] alu_y;
    logic             alu_l;
    logic             alu_v;
    logic             alu_valid;
    logic [WIDTH-1:0] ibus_out;
    logic             ibus_oe;
    logic             res_l;
    logic             res_v;
    logic             busy;
    logic             timeout;

    modport master (
        output nralu, alu_y, alu_l, alu_v, alu_valid,
        input  ibus_out, ibus_oe, res_l, res_v, busy, timeout
    );

    modport slave (
        input  nralu, alu_y, alu_l, alu_v, alu_valid,
        output ibus_out, ibus_oe, res_l, res_v, busy, timeout
    );
endinterface

`default_nettype wire

// File: rtl/pb3_rd_timeout.sv
// ============================================================================
// Module  : pb3_rd_timeout
// Brief   : Saturating 3-bit wait counter with clear/enable and expiry flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pb3_rd_timeout #(
    parameter int TIMEOUT = pb3_pkg::C_DEF_TIMEOUT
) (
    input  wire logic clk,
    input  wire logic nreset,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);
    localparam logic [2:0] C_LAST = 3'(TIMEOUT - 1);
    localparam logic [2:0] C_MAX  = 3'd7;

    logic [2:0] r_count;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_count <= 3'd0;
        end else if (clr) begin
            r_count <= 3'd0;
        end else if (en && (r_count != C_MAX)) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign expired = (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/pb3_alu_read.sv
// ============================================================================
// Module  : pb3_alu_read
// Brief   : Captures ALU result/flags on a read request and drives them on IBUS.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pb3_alu_read
    import pb3_pkg::*;
#(
    parameter int WIDTH   = C_DEF_WIDTH,
    parameter int TIMEOUT = C_DEF_TIMEOUT
) (
    input  wire logic       clk,
    input  wire logic       nreset,
    pb3_alu_read_if.slave   bus
);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_hold;
    logic             r_l;
    logic             r_v;
    logic             r_oe;
    logic             r_busy;
    logic             r_to;

    logic w_capture;
    logic w_clr;
    logic w_en;
    logic w_set_to;
    logic w_expired;

    pb3_rd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .nreset  (nreset),
        .clr     (w_clr),
        .en      (w_en),
        .expired (w_expired)
    );

    // Valid wins over expiry in WAIT: a result arriving on the last edge is still taken.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_clr     = 1'b0;
        w_en      = 1'b0;
        w_set_to  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.nralu) begin
                    if (bus.alu_valid) begin
                        w_capture = 1'b1;
                        w_next    = ST_DRIVE;
                    end else begin
                        w_clr  = 1'b1;
                        w_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.nralu) begin
                    w_next = ST_IDLE;
                end else if (bus.alu_valid) begin
                    w_capture = 1'b1;
                    w_next    = ST_DRIVE;
                end else if (w_expired) begin
                    w_set_to = 1'b1;
                    w_next   = ST_TURN;
                end else begin
                    w_en = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (bus.nralu) begin
                    w_next = ST_TURN;
                end
            end
            ST_TURN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_l     <= 1'b0;
            r_v     <= 1'b0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_oe    <= (w_next == ST_DRIVE);
            r_busy  <= (w_next != ST_IDLE);
            if (w_capture) begin
                r_hold <= bus.alu_y;
                r_l    <= bus.alu_l;
                r_v    <= bus.alu_v;
            end
            if (w_set_to) begin
                r_to <= 1'b1;
            end
        end
    end

    assign bus.ibus_out = r_hold;
    assign bus.ibus_oe  = r_oe;
    assign bus.res_l    = r_l;
    assign bus.res_v    = r_v;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_to;

endmodule

`default_nettype wire

// File: tb/tb_pb3_alu_read.sv
// ============================================================================
// Module  : tb_pb3_alu_read
// Brief   : Directed + random bench for pb3_alu_read against a read-cycle model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pb3_alu_read;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;

    logic clk;
    logic nreset;

    pb3_alu_read_if #(.WIDTH(WIDTH)) bus ();

    pb3_alu_read #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model of a read cycle: what phase of the transaction we are in.
    localparam int P_IDLE = 0, P_WAITING = 1, P_DRIVING = 2, P_TURNAROUND = 3;
    int               m_phase;
    int               m_waited;
    logic [WIDTH-1:0] m_hold;
    logic             m_l;
    logic             m_v;
    logic             m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_waited = 0;
        m_hold   = '0;
        m_l      = 1'b0;
        m_v      = 1'b0;
        m_to     = 1'b0;
    endtask

    task automatic model_take();
        m_hold  = bus.alu_y;
        m_l     = bus.alu_l;
        m_v     = bus.alu_v;
        m_phase = P_DRIVING;
    endtask

    task automatic model_edge();
        if (m_phase == P_IDLE) begin
            if (!bus.nralu) begin
                if (bus.alu_valid) model_take();
                else begin
                    m_waited = 0;
                    m_phase  = P_WAITING;
                end
            end
        end else if (m_phase == P_WAITING) begin
            if (bus.nralu) m_phase = P_IDLE;
            else if (bus.alu_valid) model_take();
            else begin
                m_waited = m_waited + 1;
                if (m_waited >= TIMEOUT) begin
                    m_to    = 1'b1;
                    m_phase = P_TURNAROUND;
                end
            end
        end else if (m_phase == P_DRIVING) begin
            if (bus.nralu) m_phase = P_TURNAROUND;
        end else begin
            m_phase = P_IDLE;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".oe"},      32'(bus.ibus_oe),  32'(m_phase == P_DRIVING));
        check({tag, ".busy"},    32'(bus.busy),     32'(m_phase != P_IDLE));
        check({tag, ".out"},     32'(bus.ibus_out), 32'(m_hold));
        check({tag, ".res_l"},   32'(bus.res_l),    32'(m_l));
        check({tag, ".res_v"},   32'(bus.res_v),    32'(m_v));
        check({tag, ".timeout"}, 32'(bus.timeout),  32'(m_to));
    endtask

    // One rising edge, then outputs compared on the following falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (nreset) model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic set_alu(input logic [WIDTH-1:0] y, input logic l, input logic v, input logic valid);
        bus.alu_y     = y;
        bus.alu_l     = l;
        bus.alu_v     = v;
        bus.alu_valid = valid;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        nreset    = 1'b0;
        bus.nralu = 1'b1;
        set_alu('0, 1'b0, 1'b0, 1'b0);

        #12;
        compare_all("reset");
        @(negedge clk);
        nreset = 1'b1;
        tick("idle");

        // Immediate read, request held for three cycles.
        set_alu(16'hA5C3, 1'b1, 1'b0, 1'b1);
        bus.nralu = 1'b0;
        for (int i = 0; i < 3; i++) tick("imm");
        check("imm.data", 32'(bus.ibus_out), 32'h0000_A5C3);
        check("imm.oe", 32'(bus.ibus_oe), 32'd1);
        bus.nralu = 1'b1;
        tick("imm_rel");
        check("imm.rel_oe", 32'(bus.ibus_oe), 32'd0);
        tick("imm_turn");

        // Late valid after three waiting edges.
        set_alu(16'h1111, 1'b0, 1'b1, 1'b0);
        bus.nralu = 1'b0;
        for (int i = 0; i < 3; i++) tick("late_wait");
        check("late.oe_before", 32'(bus.ibus_oe), 32'd0);
        set_alu(16'h00FF, 1'b0, 1'b1, 1'b1);
        tick("late_cap");
        check("late.data", 32'(bus.ibus_out), 32'h0000_00FF);
        check("late.to", 32'(bus.timeout), 32'd0);
        tick("late_drv");
        bus.nralu = 1'b1;
        tick("late_rel");
        tick("late_turn");

        // Holding register is stable while alu_y moves under it.
        set_alu(16'hBEEF, 1'b1, 1'b1, 1'b1);
        bus.nralu = 1'b0;
        tick("stab_cap");
        set_alu(16'h0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("stab_drv");
        check("stab.data", 32'(bus.ibus_out), 32'h0000_BEEF);
        bus.nralu = 1'b1;
        tick("stab_rel");
        tick("stab_turn");

        // Timeout with valid never arriving.
        set_alu(16'h7777, 1'b0, 1'b0, 1'b0);
        bus.nralu = 1'b0;
        for (int i = 0; i < 10; i++) tick("to_wait");
        check("to.flag", 32'(bus.timeout), 32'd1);
        bus.nralu = 1'b1;
        tick("to_idle");
        set_alu(16'h4242, 1'b0, 1'b1, 1'b1);
        bus.nralu = 1'b0;
        tick("to_read");
        bus.nralu = 1'b1;
        tick("to_rel");
        tick("to_turn");
        check("to.sticky", 32'(bus.timeout), 32'd1);

        // Back-to-back: one-cycle release, then a new request.
        set_alu(16'h2222, 1'b0, 1'b0, 1'b1);
        bus.nralu = 1'b0;
        tick("b2b_first");
        bus.nralu = 1'b1;
        tick("b2b_rel");
        set_alu(16'h8001, 1'b1, 1'b0, 1'b1);
        bus.nralu = 1'b0;
        tick("b2b_turn");
        check("b2b.turn_oe", 32'(bus.ibus_oe), 32'd0);
        tick("b2b_idle");
        tick("b2b_second");
        check("b2b.data", 32'(bus.ibus_out), 32'h0000_8001);
        bus.nralu = 1'b1;
        tick("b2b_rel2");
        tick("b2b_turn2");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.nralu     = ($urandom_range(0, 9) < 3);
            bus.alu_valid = ($urandom_range(0, 7) < 2);
            bus.alu_y     = WIDTH'($urandom);
            bus.alu_l     = 1'($urandom);
            bus.alu_v     = 1'($urandom);
            tick("rand");
        end
        bus.nralu = 1'b1;
        tick("rand_end");
        tick("rand_end");

        // Asynchronous reset in the middle of a drive.
        set_alu(16'h1234, 1'b1, 1'b1, 1'b1);
        bus.nralu = 1'b0;
        tick("rst_cap");
        tick("rst_drv");
        check("rst.pre_oe", 32'(bus.ibus_oe), 32'd1);
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        compare_all("rst_async");
        check("rst.oe", 32'(bus.ibus_oe), 32'd0);
        bus.nralu = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        tick("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
